// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver with a hold-until-acknowledged byte handshake.
// Ports:
//   clk         system clock, rising edge
//   reset       asynchronous active-high reset
//   rxd         serial input, idle high, asynchronous to clk
//   rx_data     last accepted byte, stable while rx_valid=1
//   rx_valid    byte available; cleared the cycle after rx_ack
//   rx_ack      consumer has taken rx_data (ignored when rx_valid=0)
//   busy        receiver is not idle
//   frame_err   sticky: stop bit sampled low
//   overrun_err sticky: byte completed while previous byte still unacknowledged
//   err_clear   clears both sticky error flags
module uart_rx #(
  parameter int unsigned CLKS_PER_BIT = 868,
  parameter int unsigned CNT_W        = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rxd,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ack,
  output logic       busy,
  output logic       frame_err,
  output logic       overrun_err,
  input  logic       err_clear
);

  localparam logic [CNT_W-1:0] HALF_CNT = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BREAK
  } state_t;

  state_t           state, state_nx;
  logic             rxd_m, rxd_s;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic [2:0]       bit_idx, bit_idx_nx;
  logic [7:0]       shift, shift_nx;
  logic [7:0]       rx_data_nx;
  logic             rx_valid_nx, busy_nx, frame_err_nx, overrun_err_nx;

  // Two-flop synchronizer; presets high so reset release never looks like a start bit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rxd_m <= 1'b1;
      rxd_s <= 1'b1;
    end else begin
      rxd_m <= rxd;
      rxd_s <= rxd_m;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= S_IDLE;
      cnt         <= '0;
      bit_idx     <= '0;
      shift       <= '0;
      rx_data     <= '0;
      rx_valid    <= 1'b0;
      busy        <= 1'b0;
      frame_err   <= 1'b0;
      overrun_err <= 1'b0;
    end else begin
      state       <= state_nx;
      cnt         <= cnt_nx;
      bit_idx     <= bit_idx_nx;
      shift       <= shift_nx;
      rx_data     <= rx_data_nx;
      rx_valid    <= rx_valid_nx;
      busy        <= busy_nx;
      frame_err   <= frame_err_nx;
      overrun_err <= overrun_err_nx;
    end
  end

  // Next-state, datapath and flag logic. Handshake/clear are applied first so
  // that byte acceptance and error setting in the same cycle take priority.
  always_comb begin
    state_nx       = state;
    cnt_nx         = cnt;
    bit_idx_nx     = bit_idx;
    shift_nx       = shift;
    rx_data_nx     = rx_data;
    rx_valid_nx    = rx_valid;
    frame_err_nx   = frame_err;
    overrun_err_nx = overrun_err;

    if (rx_valid && rx_ack) rx_valid_nx = 1'b0;
    if (err_clear) begin
      frame_err_nx   = 1'b0;
      overrun_err_nx = 1'b0;
    end

    case (state)
      S_IDLE: begin
        cnt_nx = '0;
        if (!rxd_s) state_nx = S_START;
      end
      S_START: begin
        if (cnt == HALF_CNT) begin
          cnt_nx     = '0;
          bit_idx_nx = '0;
          state_nx   = rxd_s ? S_IDLE : S_DATA;
        end else begin
          cnt_nx = cnt + CNT_W'(1);
        end
      end
      S_DATA: begin
        if (cnt == FULL_CNT) begin
          cnt_nx            = '0;
          shift_nx[bit_idx] = rxd_s;
          bit_idx_nx        = bit_idx + 3'd1;
          if (bit_idx == 3'd7) state_nx = S_STOP;
        end else begin
          cnt_nx = cnt + CNT_W'(1);
        end
      end
      S_STOP: begin
        if (cnt == FULL_CNT) begin
          cnt_nx = '0;
          if (rxd_s) begin
            // Returning to IDLE at mid stop bit leaves half a bit of margin for the next start.
            state_nx = S_IDLE;
            if (!rx_valid || rx_ack) begin
              rx_data_nx  = shift;
              rx_valid_nx = 1'b1;
            end else begin
              overrun_err_nx = 1'b1;
            end
          end else begin
            frame_err_nx = 1'b1;
            state_nx     = S_BREAK;
          end
        end else begin
          cnt_nx = cnt + CNT_W'(1);
        end
      end
      S_BREAK: begin
        // Hold off until the line idles so a stuck-low line reports one error only.
        cnt_nx = '0;
        if (rxd_s) state_nx = S_IDLE;
      end
      default: begin
        cnt_nx   = '0;
        state_nx = S_IDLE;
      end
    endcase

    busy_nx = (state_nx != S_IDLE);
  end

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed self-checking bench for uart_rx at 16 clocks per bit.
module tb_uart_rx;

  localparam int unsigned CPB = 16;

  logic       clk = 1'b0;
  logic       reset;
  logic       rxd;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ack;
  logic       busy;
  logic       frame_err;
  logic       overrun_err;
  logic       err_clear;

  int checks = 0;
  int errors = 0;
  int valid_rises = 0;
  int base;
  int lat;
  logic valid_q = 1'b0;

  uart_rx #(.CLKS_PER_BIT(CPB), .CNT_W(16)) dut (
    .clk         (clk),
    .reset       (reset),
    .rxd         (rxd),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .rx_ack      (rx_ack),
    .busy        (busy),
    .frame_err   (frame_err),
    .overrun_err (overrun_err),
    .err_clear   (err_clear)
  );

  always #5 clk = ~clk;

  // Count rx_valid assertions to catch missing or phantom bytes.
  always @(posedge clk) begin
    valid_q <= rx_valid;
    if (rx_valid && !valid_q) valid_rises <= valid_rises + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop);
    rxd = 1'b0;
    tick(CPB);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      tick(CPB);
    end
    rxd = stop;
    tick(CPB);
    rxd = 1'b1;
  endtask

  task automatic ack_pulse();
    rx_ack = 1'b1;
    tick(1);
    rx_ack = 1'b0;
  endtask

  initial begin
    reset = 1'b1; rxd = 1'b1; rx_ack = 1'b0; err_clear = 1'b0;
    tick(3);
    check("reset_valid", 32'(rx_valid), 0);
    check("reset_data", 32'(rx_data), 0);
    check("reset_busy", 32'(busy), 0);
    check("reset_ferr", 32'(frame_err), 0);
    check("reset_oerr", 32'(overrun_err), 0);
    reset = 1'b0;
    tick(4);

    // Single byte with latency: start edge -> rx_valid is 2 sync + 8 + 8*16 + 16 + 1.
    fork
      send_frame(8'hA5, 1'b1);
      begin
        lat = 0;
        while (!rx_valid && lat < 400) begin
          tick(1);
          lat++;
        end
      end
    join
    check("a5_latency", 32'(lat), 155);
    check("a5_data", 32'(rx_data), 32'h0A5);
    check("a5_valid", 32'(rx_valid), 1);
    ack_pulse();
    check("a5_ack_clears", 32'(rx_valid), 0);
    tick(4);

    // Back-to-back bytes, each acknowledged.
    base = valid_rises;
    send_frame(8'h00, 1'b1);
    check("b2b_00", 32'(rx_data), 32'h00);
    check("b2b_00_valid", 32'(rx_valid), 1);
    ack_pulse();
    send_frame(8'hFF, 1'b1);
    check("b2b_ff", 32'(rx_data), 32'hFF);
    ack_pulse();
    send_frame(8'h3C, 1'b1);
    check("b2b_3c", 32'(rx_data), 32'h3C);
    ack_pulse();
    check("b2b_rises", 32'(valid_rises - base), 3);
    check("b2b_ferr", 32'(frame_err), 0);
    check("b2b_oerr", 32'(overrun_err), 0);

    // Overrun: second byte dropped while first is unacknowledged.
    send_frame(8'h11, 1'b1);
    send_frame(8'h22, 1'b1);
    check("ovr_data", 32'(rx_data), 32'h11);
    check("ovr_flag", 32'(overrun_err), 1);
    err_clear = 1'b1;
    tick(1);
    err_clear = 1'b0;
    check("ovr_cleared", 32'(overrun_err), 0);
    check("ovr_valid_kept", 32'(rx_valid), 1);
    ack_pulse();
    check("ovr_acked", 32'(rx_valid), 0);

    // Framing error followed by a long break.
    base = valid_rises;
    send_frame(8'h5A, 1'b0);
    rxd = 1'b0;
    tick(100 * CPB);
    check("brk_ferr", 32'(frame_err), 1);
    check("brk_valid", 32'(rx_valid), 0);
    check("brk_busy", 32'(busy), 1);
    check("brk_no_phantom", 32'(valid_rises - base), 0);
    rxd = 1'b1;
    tick(5);
    check("brk_exit_busy", 32'(busy), 0);
    err_clear = 1'b1;
    tick(1);
    err_clear = 1'b0;
    check("brk_ferr_cleared", 32'(frame_err), 0);
    send_frame(8'h7E, 1'b1);
    check("post_brk_data", 32'(rx_data), 32'h7E);
    check("post_brk_valid", 32'(rx_valid), 1);
    check("post_brk_ferr", 32'(frame_err), 0);
    ack_pulse();
    tick(4);

    // Short glitch on idle line is rejected at mid start bit.
    base = valid_rises;
    rxd = 1'b0;
    tick(4);
    rxd = 1'b1;
    lat = 4;
    while (busy && lat < 40) begin
      tick(1);
      lat++;
    end
    check("glitch_busy_time_ok", 32'(lat <= int'(CPB / 2 + 3)), 1);
    tick(2 * CPB);
    check("glitch_no_byte", 32'(valid_rises - base), 0);
    check("glitch_ferr", 32'(frame_err), 0);
    check("glitch_oerr", 32'(overrun_err), 0);

    // Reset during data bit 4 of a frame.
    fork
      send_frame(8'h99, 1'b1);
      begin
        tick(11 + 4 * CPB + 8);
        reset = 1'b1;
        #1;
        check("mid_rst_busy", 32'(busy), 0);
        check("mid_rst_data", 32'(rx_data), 0);
        check("mid_rst_valid", 32'(rx_valid), 0);
        check("mid_rst_ferr", 32'(frame_err), 0);
        check("mid_rst_oerr", 32'(overrun_err), 0);
      end
    join
    tick(2);
    reset = 1'b0;
    tick(4);
    send_frame(8'hC3, 1'b1);
    check("post_rst_data", 32'(rx_data), 32'hC3);
    check("post_rst_valid", 32'(rx_valid), 1);
    check("post_rst_ferr", 32'(frame_err), 0);
    ack_pulse();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- Serial receiver for the host link on the miner board: 8N1 frames in on rxd, parallel bytes out.
- Bytes are delivered to the command/work loader with a hold-until-acknowledged handshake.
- Complements the existing transmitter on txd: same baud, same framing, LSB first.
- Single clock domain; rxd is treated as fully asynchronous.

Parameters:
- CLKS_PER_BIT, 868, clock cycles per bit period (100 MHz / 115200); legal range 8..65535.
- CNT_W, 16, width of the bit-period counter; must hold CLKS_PER_BIT-1.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- rxd  in  1  serial input, idle high.
- rx_data  out  8  last accepted byte; stable while rx_valid=1.
- rx_valid  out  1  high from byte acceptance until the cycle after rx_ack.
- rx_ack  in  1  consumer has taken rx_data; ignored when rx_valid=0.
- busy  out  1  high whenever state is not IDLE.
- frame_err  out  1  sticky; stop bit sampled 0.
- overrun_err  out  1  sticky; byte completed while rx_valid=1.
- err_clear  in  1  clears both sticky error flags.

Behaviour:
- Reset (async, asserted): rx_data=0, rx_valid=0, busy=0, frame_err=0, overrun_err=0, state=IDLE.
- Reset also sets both synchronizer flops to 1, so no spurious start is seen on release.
- Synchronizer: rxd passes through 2 flops to give rxd_s; all decisions use rxd_s only. Input-to-rxd_s latency is 2 cycles.
- Counter: cnt counts bit periods; bit_idx counts 0..7.
- IDLE: on rxd_s=0, load cnt=0 and go to START.
- START: on cnt=CLKS_PER_BIT/2-1 (mid start bit), sample rxd_s.
  - 1: glitch; go to IDLE with no flags.
  - 0: cnt=0, bit_idx=0, go to DATA.
- DATA: on cnt=CLKS_PER_BIT-1, sample rxd_s into shift[bit_idx] (LSB first) and reset cnt. After bit_idx=7 is sampled, go to STOP.
- STOP: on cnt=CLKS_PER_BIT-1, sample rxd_s.
  - 1 with rx_valid=0: rx_data<=shift and rx_valid<=1 in the next cycle; go to IDLE.
  - 1 with rx_valid=1: byte dropped, rx_data unchanged, overrun_err<=1; go to IDLE.
  - 0: frame_err<=1, byte dropped; go to BREAK.
- BREAK: wait until rxd_s=1, then go to IDLE. A held-low line therefore yields exactly one frame_err and no repeated frames.
- IDLE is re-entered at mid stop bit, so the next start edge is detected with half a bit of margin.
- Handshake: rx_ack=1 while rx_valid=1 clears rx_valid in the next cycle.
- Acceptance and ack in the same cycle: acceptance wins. rx_valid stays 1, new byte is loaded, no overrun.
- err_clear and an error-setting event in the same cycle: the set wins.
- busy=1 in START, DATA, STOP and BREAK.
- Reset mid-frame: immediate return to the reset state. The partial frame is discarded; reception resumes on the next falling edge after release.
- Counter arithmetic is unsigned CNT_W bits and never wraps, because it is always reset at the compare value.

Test Plan (CLKS_PER_BIT=16):
- Send 0xA5 as 8N1 at 16 clk/bit, rx_ack held 0:
  - rx_data=0xA5, rx_valid rises 1 cycle after the stop-bit mid-sample (~2+8+8*16+16 cycles after the start edge).
  - Pulse rx_ack: rx_valid=0 the next cycle.
- Back-to-back 0x00, 0xFF, 0x3C with rx_ack pulsed after each: three rx_valid assertions, correct bytes, no error flags.
- Send 0x11 then 0x22 with no ack: rx_data stays 0x11, overrun_err=1. err_clear then gives overrun_err=0, rx_valid still 1.
- Frame 0x5A with stop bit forced 0, then rxd held low for 100 bit times:
  - frame_err=1 and rx_valid=0; busy stays 1 while in BREAK.
  - Exactly one error, no phantom bytes.
  - After rxd returns high, 0x7E is received correctly.
- 4-cycle low glitch on idle rxd: no rx_valid, no flags, busy returns to 0 within CLKS_PER_BIT/2+3 cycles.
- Assert reset at data bit 4 of a frame: all outputs 0 immediately. The next full frame 0xC3 is received correctly.
